// File: rtl/spi_inert_slv.sv
// rtl/spi_inert_slv.sv - SPI mode-0 register slave serving inertial sensor snapshots
//
// Purpose: 16-bit MSB-first SPI frames (byte 1 = R/W flag + 7-bit address,
// byte 2 = write data). Sensor inputs are captured into shadow registers on
// new_data; captures arriving mid-frame are held and committed once the frame
// ends so that a byte pair never tears. INT flags fresh data and is cleared by
// reading the last data byte (0x2B).
//
// Ports:
//   clk, rst_n                      system clock, async active-low reset
//   SS_n, SCLK, MOSI                SPI inputs (asynchronous to clk)
//   MISO                            SPI data to master (0 while deselected)
//   INT                             data-ready interrupt
//   ptch_in/roll_in/yaw_in/ax_in/ay_in  16-bit signed sensor values
//   new_data                        one-cycle capture strobe
//   ovr                             sticky overrun flag
//
// Build option: define INERT_SLV_OVR_CNT_EN to add an 8-bit saturating overrun
// counter readable at 0x0F and cleared by a write to 0x0F.
module spi_inert_slv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic [15:0] ptch_in,
  input  logic [15:0] roll_in,
  input  logic [15:0] yaw_in,
  input  logic [15:0] ax_in,
  input  logic [15:0] ay_in,
  input  logic        new_data,
  output logic        ovr
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, EXEC = 2'd2} state_t;

  state_t      state_q, state_d;
  // Sync chains: [0] metastable stage, [1] synchronized copy, [2] previous copy.
  logic [2:0]  ss_q, ss_d;
  logic [2:0]  sclk_q, sclk_d;
  logic [1:0]  mosi_q, mosi_d;
  logic [15:0] rx_q, rx_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic        int_q, int_d;
  logic        ovr_q, ovr_d;
  logic        commit_q, commit_d;
  logic [7:0]  int_en_q, int_en_d;
  logic [7:0]  accl_q, accl_d;
  logic [7:0]  gyro_q, gyro_d;
  logic [7:0]  round_q, round_d;
  logic [15:0] sh_ptch_q, sh_ptch_d, sh_roll_q, sh_roll_d, sh_yaw_q, sh_yaw_d;
  logic [15:0] sh_ax_q, sh_ax_d, sh_ay_q, sh_ay_d;
  logic [15:0] pd_ptch_q, pd_ptch_d, pd_roll_q, pd_roll_d, pd_yaw_q, pd_yaw_d;
  logic [15:0] pd_ax_q, pd_ax_d, pd_ay_q, pd_ay_d;
  logic        pd_vld_q, pd_vld_d;
`ifdef INERT_SLV_OVR_CNT_EN
  logic [7:0]  ovr_cnt_q, ovr_cnt_d;
`endif

  logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [15:0] rx_shift;
  logic [7:0]  rdata;
  logic        snap;
  logic        int_clr;

  assign ss_fall   =  ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] &  ss_q[1];
  assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] &  sclk_q[2];
  assign rx_shift  = {rx_q[14:0], mosi_q[1]};

  assign MISO = miso_q;
  assign INT  = int_q;
  assign ovr  = ovr_q;

  // Read mux, addressed by byte 1 as it completes on the 8th SCLK rise.
  always_comb begin
    rdata = 8'h00;
    case (rx_shift[6:0])
      7'h0D:   rdata = int_en_q;
      7'h10:   rdata = accl_q;
      7'h11:   rdata = gyro_q;
      7'h14:   rdata = round_q;
`ifdef INERT_SLV_OVR_CNT_EN
      7'h0F:   rdata = ovr_cnt_q;
`endif
      7'h22:   rdata = sh_ptch_q[7:0];
      7'h23:   rdata = sh_ptch_q[15:8];
      7'h24:   rdata = sh_roll_q[7:0];
      7'h25:   rdata = sh_roll_q[15:8];
      7'h26:   rdata = sh_yaw_q[7:0];
      7'h27:   rdata = sh_yaw_q[15:8];
      7'h28:   rdata = sh_ax_q[7:0];
      7'h29:   rdata = sh_ax_q[15:8];
      7'h2A:   rdata = sh_ay_q[7:0];
      7'h2B:   rdata = sh_ay_q[15:8];
      default: rdata = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ss_d      = {ss_q[1:0], SS_n};
    sclk_d    = {sclk_q[1:0], SCLK};
    mosi_d    = {mosi_q[0], MOSI};
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    int_d     = int_q;
    ovr_d     = ovr_q;
    commit_d  = 1'b0;
    int_en_d  = int_en_q;
    accl_d    = accl_q;
    gyro_d    = gyro_q;
    round_d   = round_q;
    sh_ptch_d = sh_ptch_q;
    sh_roll_d = sh_roll_q;
    sh_yaw_d  = sh_yaw_q;
    sh_ax_d   = sh_ax_q;
    sh_ay_d   = sh_ay_q;
    pd_ptch_d = pd_ptch_q;
    pd_roll_d = pd_roll_q;
    pd_yaw_d  = pd_yaw_q;
    pd_ax_d   = pd_ax_q;
    pd_ay_d   = pd_ay_q;
    pd_vld_d  = pd_vld_q;
`ifdef INERT_SLV_OVR_CNT_EN
    ovr_cnt_d = ovr_cnt_q;
`endif
    snap      = 1'b0;
    int_clr   = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          state_d   = SHIFT;
          bit_cnt_d = 5'd0;
          rx_d      = 16'h0000;
          tx_d      = 8'h00;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = (bit_cnt_q == 5'd16) ? EXEC : IDLE;
          miso_d  = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_d = rx_shift;
            if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) tx_d = rx_shift[7] ? rdata : 8'h00;
          end
          if (sclk_fall) begin
            if (bit_cnt_q >= 5'd8 && bit_cnt_q <= 5'd15) begin
              miso_d = tx_q[7];
              tx_d   = {tx_q[6:0], 1'b0};
            end else begin
              miso_d = 1'b0;
            end
          end
        end
      end
      EXEC: begin
        state_d = IDLE;
        if (!rx_q[15]) begin
          case (rx_q[14:8])
            7'h0D:   int_en_d = rx_q[7:0];
            7'h10:   accl_d   = rx_q[7:0];
            7'h11:   gyro_d   = rx_q[7:0];
            7'h14:   round_d  = rx_q[7:0];
`ifdef INERT_SLV_OVR_CNT_EN
            7'h0F:   ovr_cnt_d = 8'h00;
`endif
            default: ;
          endcase
        end else if (rx_q[14:8] == 7'h2B) begin
          int_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Snapshots commit only while idle; during a frame the newest one is parked.
    if (new_data) begin
      if (state_q == IDLE) begin
        snap      = 1'b1;
        sh_ptch_d = ptch_in;
        sh_roll_d = roll_in;
        sh_yaw_d  = yaw_in;
        sh_ax_d   = ax_in;
        sh_ay_d   = ay_in;
        pd_vld_d  = 1'b0;
      end else begin
        pd_ptch_d = ptch_in;
        pd_roll_d = roll_in;
        pd_yaw_d  = yaw_in;
        pd_ax_d   = ax_in;
        pd_ay_d   = ay_in;
        pd_vld_d  = 1'b1;
      end
    end else if (pd_vld_q && state_q == IDLE) begin
      snap      = 1'b1;
      sh_ptch_d = pd_ptch_q;
      sh_roll_d = pd_roll_q;
      sh_yaw_d  = pd_yaw_q;
      sh_ax_d   = pd_ax_q;
      sh_ay_d   = pd_ay_q;
      pd_vld_d  = 1'b0;
    end

    commit_d = snap;
    if (snap && int_q) begin
      ovr_d = 1'b1;
`ifdef INERT_SLV_OVR_CNT_EN
      if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
`endif
    end

    // Set is evaluated last so it wins over a same-cycle clear.
    if (int_clr) int_d = 1'b0;
    if (commit_q && int_en_q[1]) int_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      // SS_n chain resets to "selected" so a frame already in progress at
      // release is not mistaken for a new SS_n fall.
      ss_q      <= 3'b000;
      sclk_q    <= 3'b000;
      mosi_q    <= 2'b00;
      rx_q      <= 16'h0000;
      bit_cnt_q <= 5'd0;
      tx_q      <= 8'h00;
      miso_q    <= 1'b0;
      int_q     <= 1'b0;
      ovr_q     <= 1'b0;
      commit_q  <= 1'b0;
      int_en_q  <= 8'h00;
      accl_q    <= 8'h00;
      gyro_q    <= 8'h00;
      round_q   <= 8'h00;
      sh_ptch_q <= 16'h0000;
      sh_roll_q <= 16'h0000;
      sh_yaw_q  <= 16'h0000;
      sh_ax_q   <= 16'h0000;
      sh_ay_q   <= 16'h0000;
      pd_ptch_q <= 16'h0000;
      pd_roll_q <= 16'h0000;
      pd_yaw_q  <= 16'h0000;
      pd_ax_q   <= 16'h0000;
      pd_ay_q   <= 16'h0000;
      pd_vld_q  <= 1'b0;
`ifdef INERT_SLV_OVR_CNT_EN
      ovr_cnt_q <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      ss_q      <= ss_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      int_q     <= int_d;
      ovr_q     <= ovr_d;
      commit_q  <= commit_d;
      int_en_q  <= int_en_d;
      accl_q    <= accl_d;
      gyro_q    <= gyro_d;
      round_q   <= round_d;
      sh_ptch_q <= sh_ptch_d;
      sh_roll_q <= sh_roll_d;
      sh_yaw_q  <= sh_yaw_d;
      sh_ax_q   <= sh_ax_d;
      sh_ay_q   <= sh_ay_d;
      pd_ptch_q <= pd_ptch_d;
      pd_roll_q <= pd_roll_d;
      pd_yaw_q  <= pd_yaw_d;
      pd_ax_q   <= pd_ax_d;
      pd_ay_q   <= pd_ay_d;
      pd_vld_q  <= pd_vld_d;
`ifdef INERT_SLV_OVR_CNT_EN
      ovr_cnt_q <= ovr_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_inert_slv.sv
// tb/tb_spi_inert_slv.sv - directed and randomized bench for spi_inert_slv
module tb_spi_inert_slv;

  localparam int H = 8;  // clk cycles per SCLK half period

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1, SCLK = 1'b0, MOSI = 1'b0, new_data = 1'b0;
  logic [15:0] ptch_in = '0, roll_in = '0, yaw_in = '0, ax_in = '0, ay_in = '0;
  logic        MISO, INT, ovr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_inert_slv dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .INT(INT),
    .ptch_in(ptch_in), .roll_in(roll_in), .yaw_in(yaw_in), .ax_in(ax_in), .ay_in(ay_in),
    .new_data(new_data), .ovr(ovr)
  );

  // Reference model: register map as arrays, snapshot/interrupt rules as events.
  logic [7:0]  m_cfg [128];
  logic [15:0] m_sh  [5];
  logic [15:0] m_pd  [5];
  bit          m_pd_vld, m_int, m_ovr, m_in_frame;
  int          m_cnt;

  function automatic bit is_wr(input logic [6:0] a);
    return (a == 7'h0D) || (a == 7'h10) || (a == 7'h11) || (a == 7'h14);
  endfunction

  function automatic logic [7:0] exp_read(input logic [6:0] a);
    int off;
    if (is_wr(a)) return m_cfg[a];
    if (a >= 7'h22 && a <= 7'h2B) begin
      off = int'(a) - 'h22;
      return off[0] ? m_sh[off/2][15:8] : m_sh[off/2][7:0];
    end
`ifdef INERT_SLV_OVR_CNT_EN
    if (a == 7'h0F) return 8'(m_cnt);
`endif
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_cfg[i] = 8'h00;
    for (int i = 0; i < 5; i++) begin m_sh[i] = 16'h0; m_pd[i] = 16'h0; end
    m_pd_vld = 0; m_int = 0; m_ovr = 0; m_cnt = 0; m_in_frame = 0;
  endtask

  task automatic model_apply(input logic [15:0] v0, v1, v2, v3, v4);
    if (m_int) begin
      m_ovr = 1;
      if (m_cnt < 255) m_cnt++;
    end
    m_sh[0] = v0; m_sh[1] = v1; m_sh[2] = v2; m_sh[3] = v3; m_sh[4] = v4;
    if (m_cfg[7'h0D][1]) m_int = 1;
  endtask

  task automatic model_snap(input logic [15:0] v0, v1, v2, v3, v4);
    if (m_in_frame) begin
      m_pd[0] = v0; m_pd[1] = v1; m_pd[2] = v2; m_pd[3] = v3; m_pd[4] = v4;
      m_pd_vld = 1;
    end else begin
      model_apply(v0, v1, v2, v3, v4);
    end
  endtask

  task automatic model_frame_end(input logic [15:0] w, input int nedges);
    m_in_frame = 0;
    if (nedges == 16) begin
      if (!w[15]) begin
        if (is_wr(w[14:8])) m_cfg[w[14:8]] = w[7:0];
        if (w[14:8] == 7'h0F) m_cnt = 0;
      end else if (w[14:8] == 7'h2B) begin
        m_int = 0;
      end
    end
    if (m_pd_vld) begin
      m_pd_vld = 0;
      model_apply(m_pd[0], m_pd[1], m_pd[2], m_pd[3], m_pd[4]);
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] v0, v1, v2, v3, v4);
    ptch_in = v0; roll_in = v1; yaw_in = v2; ax_in = v3; ay_in = v4;
    new_data = 1'b1;
    tick(1);
    new_data = 1'b0;
    model_snap(v0, v1, v2, v3, v4);
  endtask

  // act 1: two mid-frame snapshots (0x5555 then 0x6666); act 2: reset pulse.
  task automatic spi_frame(input logic [15:0] word, input int nedges,
                           input int act_at, input int act, output logic [7:0] rdb);
    bit aborted;
    aborted = 0;
    rdb = 8'h00;
    m_in_frame = 1;
    SS_n = 1'b0;
    tick(4);
    for (int i = 0; i < nedges; i++) begin
      MOSI = word[15 - (i % 16)];
      tick(H);
      if (i >= 8 && i < 16) rdb = {rdb[6:0], MISO};
      SCLK = 1'b1;
      tick(H);
      SCLK = 1'b0;
      if (i == act_at && act == 1) begin
        pulse(16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h5555);
        tick(3);
        pulse(16'h6666, 16'h6666, 16'h6666, 16'h6666, 16'h6666);
      end
      if (i == act_at && act == 2) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        model_reset();
        aborted = 1;
        tick(1);
        check("rst_int", {15'd0, INT}, 16'd0);
        check("rst_miso", {15'd0, MISO}, 16'd0);
      end
    end
    tick(H);
    SS_n = 1'b1;
    tick(10);
    if (!aborted) model_frame_end(word, nedges);
    m_in_frame = 0;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] rdb;
    spi_frame({1'b0, a, d}, 16, -1, 0, rdb);
    check("wr_int", {15'd0, INT}, {15'd0, m_int});
  endtask

  task automatic do_read(input logic [6:0] a, output logic [7:0] rdb);
    logic [7:0] exp;
    exp = exp_read(a);
    spi_frame({1'b1, a, 8'h00}, 16, -1, 0, rdb);
    check($sformatf("rd_%02h", a), {8'd0, rdb}, {8'd0, exp});
    check("rd_int", {15'd0, INT}, {15'd0, m_int});
    check("rd_ovr", {15'd0, ovr}, {15'd0, m_ovr});
    check("idle_miso", {15'd0, MISO}, 16'd0);
  endtask

  logic [6:0] wlist [9] = '{7'h0D, 7'h10, 7'h11, 7'h14, 7'h0F, 7'h2B, 7'h22, 7'h05, 7'h7F};
  logic [6:0] rlist [17] = '{7'h0D, 7'h10, 7'h11, 7'h14, 7'h0F, 7'h22, 7'h23, 7'h24, 7'h25,
                             7'h26, 7'h27, 7'h28, 7'h29, 7'h2A, 7'h2B, 7'h00, 7'h7F};

  initial begin
    logic [7:0] rb;
    int k;
    model_reset();
    tick(3);
    rst_n = 1'b1;
    tick(4);
    check("reset_int", {15'd0, INT}, 16'd0);
    check("reset_ovr", {15'd0, ovr}, 16'd0);
    check("reset_miso", {15'd0, MISO}, 16'd0);
    do_read(7'h0D, rb);
    do_read(7'h22, rb);

    // Enable INT, capture pitch 0x1234, INT must rise within two cycles.
    do_write(7'h0D, 8'h02);
    ptch_in = 16'h1234; ay_in = 16'($urandom);
    new_data = 1'b1;
    tick(1);
    new_data = 1'b0;
    model_snap(16'h1234, roll_in, yaw_in, ax_in, ay_in);
    k = 0;
    while (k < 2 && INT !== 1'b1) begin tick(1); k++; end
    check("int_rise", {15'd0, INT}, 16'd1);
    tick(2);
    do_read(7'h22, rb); check("ptch_l_34", {8'd0, rb}, 16'h0034);
    do_read(7'h23, rb); check("ptch_h_12", {8'd0, rb}, 16'h0012);

    // Second capture with no 0x2B read in between -> overrun.
    pulse(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hBEEF);
    tick(3);
    check("ovr_set", {15'd0, ovr}, 16'd1);
    do_read(7'h0F, rb);
`ifdef INERT_SLV_OVR_CNT_EN
    check("ovr_cnt", {8'd0, rb}, 16'h0001);
`else
    check("ovr_cnt", {8'd0, rb}, 16'h0000);
`endif

    // Full ten-byte read; INT only drops after the 0x2B frame.
    for (int a = 'h22; a <= 'h2B; a++) begin
      do_read(7'(a), rb);
      check("int_seq", {15'd0, INT}, (a == 'h2B) ? 16'd0 : 16'd1);
    end
    do_read(7'h2A, rb); check("ay_l_ef", {8'd0, rb}, 16'h00EF);

    // Aborted partial frame, then full write.
    spi_frame(16'h1062, 9, -1, 0, rb);
    do_read(7'h10, rb); check("accl_abort", {8'd0, rb}, 16'h0000);
    do_write(7'h10, 8'h62);
    do_read(7'h10, rb); check("accl_62", {8'd0, rb}, 16'h0062);

    // Over-long frames abort; 48 edges would land on 16 if the counter wrapped.
    spi_frame(16'h1177, 48, -1, 0, rb);
    spi_frame(16'h1177, 20, -1, 0, rb);
    do_read(7'h11, rb); check("gyro_long", {8'd0, rb}, 16'h0000);

    // Mid-frame captures are deferred; newest wins.
    begin
      logic [7:0] exp_old;
      exp_old = exp_read(7'h22);
      spi_frame(16'hA200, 16, 10, 1, rb);
      check("defer_old", {8'd0, rb}, {8'd0, exp_old});
    end
    do_read(7'h22, rb); check("defer_new_l", {8'd0, rb}, 16'h0066);
    do_read(7'h23, rb); check("defer_new_h", {8'd0, rb}, 16'h0066);

    // Randomized mix of writes, captures and reads against the model.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 2))
        0: do_write(wlist[$urandom_range(0, 8)], 8'($urandom));
        1: begin
          pulse(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
          tick(3);
          check("rnd_int", {15'd0, INT}, {15'd0, m_int});
          check("rnd_ovr", {15'd0, ovr}, {15'd0, m_ovr});
        end
        default: do_read(rlist[$urandom_range(0, 16)], rb);
      endcase
    end

    // Reset in the middle of a read with INT high.
    do_write(7'h0D, 8'h02);
    pulse(16'hCAFE, 16'h1, 16'h2, 16'h3, 16'h4);
    tick(3);
    check("pre_rst_int", {15'd0, INT}, 16'd1);
    spi_frame(16'hA200, 16, 4, 2, rb);
    check("rst_frame_rd", {8'd0, rb}, 16'h0000);
    check("rst_ovr", {15'd0, ovr}, 16'd0);
    do_read(7'h22, rb); check("rst_shadow", {8'd0, rb}, 16'h0000);
    do_read(7'h0D, rb); check("rst_cfg", {8'd0, rb}, 16'h0000);
    do_write(7'h14, 8'h62);
    do_read(7'h14, rb); check("post_rst_wr", {8'd0, rb}, 16'h0062);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
